// File: rtl/spi_master_burst.sv
// rtl/spi_master_burst.sv - burst SPI master, CSN held low across multi-word transfers
// Optional build macro SPI_LOOPBACK_EN: sample internal mosi instead of miso (self-test).
module spi_master_burst #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 5,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int CS_SETUP = 2
) (
    input  logic              clk_10,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    output logic              csn,
    input  logic              miso
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CS_LAST   = CNT_W'(CS_SETUP - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic CPOL_L = (CPOL != 0);
    localparam logic CPHA_L = (CPHA != 0);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              last_q;
    logic              sck_q;
    logic              mosi_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              sample_bit;
    logic [DATA_W-1:0] rx_shifted;
    logic [DATA_W-1:0] rx_word;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = miso;
`endif

    assign rx_shifted = {rx_shift[DATA_W-2:0], sample_bit};
    // CPHA=1 takes its last sample on the final trailing edge itself.
    assign rx_word    = CPHA_L ? rx_shifted : rx_shift;

    assign tx_ready = rst_n && ((state == ST_IDLE) || (state == ST_NEXT));
    assign busy     = (state != ST_IDLE);
    assign csn      = (state == ST_IDLE);
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    always_ff @(posedge clk_10) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            edge_cnt   <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            last_q     <= 1'b0;
            sck_q      <= CPOL_L;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        last_q   <= tx_last;
                        cnt      <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CS_LAST) begin
                        cnt      <= '0;
                        edge_cnt <= '0;
                        state    <= ST_SHIFT;
                        if (!CPHA_L) begin
                            mosi_q <= tx_shift[DATA_W-1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        sck_q    <= ~sck_q;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (!edge_cnt[0]) begin
                            if (CPHA_L) begin
                                mosi_q   <= tx_shift[DATA_W-1];
                                tx_shift <= tx_shift << 1;
                            end else begin
                                rx_shift <= rx_shifted;
                            end
                        end else begin
                            if (CPHA_L) begin
                                rx_shift <= rx_shifted;
                            end else begin
                                mosi_q   <= tx_shift[DATA_W-2];
                                tx_shift <= tx_shift << 1;
                            end
                            if (edge_cnt == EDGE_LAST) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= rx_word;
                                state      <= last_q ? ST_HOLD : ST_NEXT;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        last_q   <= tx_last;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        state    <= ST_SHIFT;
                        if (!CPHA_L) begin
                            mosi_q <= tx_data[DATA_W-1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == CS_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_burst.sv
// tb/tb_spi_master_burst.sv - directed bench for spi_master_burst (mode 0 default and mode 3 instance)
module tb_spi_master_burst;
    logic       clk_10 = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_last, tx_ready, rx_valid, busy, sck, mosi, csn, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid3, tx_last3, tx_ready3, rx_valid3, busy3, sck3, mosi3, csn3, miso3;
    logic [7:0] tx_data3, rx_data3;

    always #5 clk_10 = ~clk_10;

    spi_master_burst dut (
        .clk_10(clk_10), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sck(sck), .mosi(mosi), .csn(csn), .miso(miso)
    );

    spi_master_burst #(.CPOL(1), .CPHA(1)) dut3 (
        .clk_10(clk_10), .rst_n(rst_n), .tx_valid(tx_valid3), .tx_data(tx_data3),
        .tx_last(tx_last3), .tx_ready(tx_ready3), .rx_valid(rx_valid3), .rx_data(rx_data3),
        .busy(busy3), .sck(sck3), .mosi(mosi3), .csn(csn3), .miso(miso3)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk_10) cyc <= cyc + 1;

    // Monitor and slave model for the mode-0 instance.
    int         rx_cnt, rise_cnt, bad_period, bad_mosi, csn_fall, csn_rise_cyc, last_rise;
    int         rx_cyc [4];
    logic [7:0] rx_word [4];
    logic [15:0] mosi_cap;
    logic [7:0] miso_list [4];
    int         widx, bit_idx;
    logic       sck_p = 1'b0, csn_p = 1'b1, mosi_p = 1'b0;
    logic [7:0] cur_miso;

    always @(negedge clk_10) begin
        if (rx_valid === 1'b1) begin
            if (rx_cnt < 4) begin
                rx_cyc[rx_cnt]  = cyc;
                rx_word[rx_cnt] = rx_data;
            end
            rx_cnt++;
            last_rise = -1;
        end
        if (sck === 1'b1 && sck_p === 1'b0) begin
            rise_cnt++;
            if (last_rise >= 0 && (cyc - last_rise) != 10) bad_period++;
            last_rise = cyc;
            mosi_cap  = {mosi_cap[14:0], mosi};
            bit_idx++;
        end
        if (sck === 1'b1 && mosi !== mosi_p) bad_mosi++;
        if (csn === 1'b0 && csn_p === 1'b1) csn_fall++;
        if (csn === 1'b1 && csn_p === 1'b0) csn_rise_cyc = cyc;
        if (csn === 1'b1 || rx_valid === 1'b1) begin
            if (rx_valid === 1'b1) widx++;
            bit_idx = 0;
        end
        cur_miso = miso_list[widx % 4];
        miso     = (bit_idx < 8) ? cur_miso[7 - bit_idx] : 1'b0;
        sck_p  = sck;
        csn_p  = csn;
        mosi_p = mosi;
    end

    // Monitor and slave model for the mode-3 instance.
    int         rx3_cnt = 0, rise3 = 0, bad_mosi3 = 0, idle_bad3 = 0, bit3 = 0;
    logic [7:0] rx3_word, mosi3_cap, miso3_word;
    logic       sck3_p = 1'b1, mosi3_p = 1'b0;

    always @(negedge clk_10) begin
        if (rx_valid3 === 1'b1) begin
            rx3_cnt++;
            rx3_word = rx_data3;
        end
        if (sck3 === 1'b1 && sck3_p === 1'b0) begin
            rise3++;
            mosi3_cap = {mosi3_cap[6:0], mosi3};
            bit3++;
        end
        if (mosi3 !== mosi3_p && !(sck3_p === 1'b1 && sck3 === 1'b0)) bad_mosi3++;
        if (csn3 === 1'b1 && sck3 !== 1'b1) idle_bad3++;
        if (csn3 === 1'b1 || rx_valid3 === 1'b1) bit3 = 0;
        miso3   = (bit3 < 8) ? miso3_word[7 - bit3] : 1'b0;
        sck3_p  = sck3;
        mosi3_p = mosi3;
    end

    function automatic logic [7:0] exp_rx(input logic [7:0] sent, input logic [7:0] slave);
`ifdef SPI_LOOPBACK_EN
        return sent;
`else
        return slave;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic clear_mon();
        rx_cnt = 0; rise_cnt = 0; bad_period = 0; bad_mosi = 0;
        csn_fall = 0; csn_rise_cyc = -1; last_rise = -1; mosi_cap = '0;
        widx = 0; bit_idx = 0;
    endtask

    task automatic offer(input logic [7:0] d, input logic l);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
    endtask

    // Called at a negedge with tx_valid high; returns at the negedge after acceptance.
    task automatic wait_accept(output int acc);
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk_10);
        end
        if (acc < 0) timeout("accept");
        else @(negedge clk_10);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 400 && rx_cnt < n; i++) @(negedge clk_10);
        if (rx_cnt < n) timeout("rx_valid");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && !(csn === 1'b1 && busy === 1'b0); i++) @(negedge clk_10);
        @(negedge clk_10);
        if (!(csn === 1'b1 && busy === 1'b0)) timeout("idle");
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] slave;
        int         lat;
    } vec_t;

    vec_t vecs [5];
    int   acc, acc2, viol;

    initial begin
        vecs[0] = '{data: 8'hA5, slave: 8'h3C, lat: 83};
        vecs[1] = '{data: 8'h00, slave: 8'hFF, lat: 83};
        vecs[2] = '{data: 8'hFF, slave: 8'h00, lat: 83};
        vecs[3] = '{data: 8'h81, slave: 8'h7E, lat: 83};
        vecs[4] = '{data: 8'h5A, slave: 8'h00, lat: 83};

        rst_n = 1'b0;
        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        tx_valid3 = 1'b0; tx_data3 = '0; tx_last3 = 1'b0;
        miso = 1'b0; miso3 = 1'b0; miso3_word = '0;
        for (int i = 0; i < 4; i++) miso_list[i] = '0;
        clear_mon();
        repeat (3) @(negedge clk_10);
        check("reset_tx_ready", tx_ready, 0);
        check("reset_csn", csn, 1);
        check("reset_sck", sck, 0);
        check("reset_mosi", mosi, 0);
        check("reset_busy", busy, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_sck_mode3", sck3, 1);
        rst_n = 1'b1;
        @(negedge clk_10);
        check("ready_after_reset", tx_ready, 1);

        // Single-word transactions from the vector table.
        foreach (vecs[k]) begin
            clear_mon();
            miso_list[0] = vecs[k].slave;
            @(negedge clk_10);
            offer(vecs[k].data, 1'b1);
            wait_accept(acc);
            tx_valid = 1'b0;
            wait_rx(1);
            wait_idle();
            check("single_latency", rx_cyc[0] - acc, vecs[k].lat);
            check("single_rx_data", rx_word[0], exp_rx(vecs[k].data, vecs[k].slave));
            check("single_rx_count", rx_cnt, 1);
            check("single_csn_rise", csn_rise_cyc - rx_cyc[0], 2);
            check("single_sck_pulses", rise_cnt, 8);
            check("single_sck_period", bad_period, 0);
            check("single_mosi_bits", mosi_cap[7:0], vecs[k].data);
            check("single_mosi_stable", bad_mosi, 0);
        end

        // Burst of two words with tx_valid held high.
        clear_mon();
        miso_list[0] = 8'hC5;
        miso_list[1] = 8'h3A;
        @(negedge clk_10);
        offer(8'h20, 1'b0);
        wait_accept(acc);
        offer(8'h0F, 1'b1);
        wait_accept(acc2);
        tx_valid = 1'b0;
        wait_rx(2);
        wait_idle();
        check("burst_spacing", rx_cyc[1] - rx_cyc[0], 81);
        check("burst_accept_with_rx", acc2 - rx_cyc[0], 0);
        check("burst_rx0", rx_word[0], exp_rx(8'h20, 8'hC5));
        check("burst_rx1", rx_word[1], exp_rx(8'h0F, 8'h3A));
        check("burst_sck_pulses", rise_cnt, 16);
        check("burst_csn_lows", csn_fall, 1);
        check("burst_mosi_bits", mosi_cap, 16'h200F);
        check("burst_csn_rise", csn_rise_cyc - rx_cyc[1], 2);

        // Stall between burst words.
        clear_mon();
        miso_list[0] = 8'h55;
        miso_list[1] = 8'hAA;
        @(negedge clk_10);
        offer(8'hFF, 1'b0);
        wait_accept(acc);
        tx_valid = 1'b0;
        wait_rx(1);
        viol = 0;
        repeat (50) begin
            @(negedge clk_10);
            if (csn !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) viol++;
        end
        check("stall_hold", viol, 0);
        offer(8'h81, 1'b1);
        wait_accept(acc2);
        tx_valid = 1'b0;
        wait_rx(2);
        wait_idle();
        check("stall_rx0", rx_word[0], exp_rx(8'hFF, 8'h55));
        check("stall_rx1", rx_word[1], exp_rx(8'h81, 8'hAA));
        check("stall_csn_lows", csn_fall, 1);
        check("stall_sck_pulses", rise_cnt, 16);

        // Reset in the middle of a word.
        clear_mon();
        miso_list[0] = 8'h3C;
        @(negedge clk_10);
        offer(8'hA5, 1'b1);
        wait_accept(acc);
        tx_valid = 1'b0;
        for (int i = 0; i < 200 && rise_cnt < 4; i++) @(negedge clk_10);
        if (rise_cnt < 4) timeout("mid_word");
        repeat (3) @(negedge clk_10);
        rst_n = 1'b0;
        @(negedge clk_10);
        check("midrst_tx_ready", tx_ready, 0);
        repeat (2) @(negedge clk_10);
        check("midrst_csn", csn, 1);
        check("midrst_sck", sck, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk_10);
        check("midrst_ready_after", tx_ready, 1);
        repeat (120) @(negedge clk_10);
        check("midrst_no_rx_valid", rx_cnt, 0);

        // Normal transaction after the aborted one.
        clear_mon();
        miso_list[0] = 8'h96;
        @(negedge clk_10);
        offer(8'h3C, 1'b1);
        wait_accept(acc);
        tx_valid = 1'b0;
        wait_rx(1);
        wait_idle();
        check("post_rst_latency", rx_cyc[0] - acc, 83);
        check("post_rst_rx_data", rx_word[0], exp_rx(8'h3C, 8'h96));

        // Mode 3 instance.
        miso3_word = 8'h81;
        bad_mosi3 = 0;
        rise3 = 0;
        @(negedge clk_10);
        tx_valid3 = 1'b1; tx_data3 = 8'hC3; tx_last3 = 1'b1;
        for (int i = 0; i < 10 && tx_ready3 !== 1'b1; i++) @(negedge clk_10);
        @(negedge clk_10);
        tx_valid3 = 1'b0;
        for (int i = 0; i < 400 && rx3_cnt < 1; i++) @(negedge clk_10);
        if (rx3_cnt < 1) timeout("mode3_rx_valid");
        repeat (5) @(negedge clk_10);
        check("mode3_rx_data", rx3_word, exp_rx(8'hC3, 8'h81));
        check("mode3_sck_pulses", rise3, 8);
        check("mode3_mosi_bits", mosi3_cap, 8'hC3);
        check("mode3_mosi_on_fall", bad_mosi3, 0);
        check("mode3_sck_idle_high", idle_bad3, 0);
        check("mode3_idle_csn", csn3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
